// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
// Build option UART_TX_STOP2_EN adds a second stop state.
package uart_pkg;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic PAR_EVEN       = 1'b0;
  localparam logic PAR_ODD        = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
`ifdef UART_TX_STOP2_EN
    STOP   = 3'd4,
    STOP2  = 3'd5
`else
    STOP   = 3'd4
`endif
  } tx_state_t;

endpackage

// File: rtl/uart_tx_frame_counter.sv
// Bit-period edge counter and data bit index for the UART transmitter.
// Both hold at zero while the transmitter is idle.
module tx_baud_bit_counter #(
  parameter int PRESCALE_WIDTH = 5,
  parameter int DATA_WIDTH     = 8,
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic                      bit_cnt_en_i,
  output logic [PRESCALE_WIDTH-1:0] cnt_o,
  output logic [IW-1:0]             idx_o,
  output logic [IW-1:0]             idx_nxt_o,
  output logic                      bit_end_o
);

  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;

  assign bit_end_o = en_i & (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!en_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else begin
      cnt_d = bit_end_o ? '0 : cnt_q + 1'b1;
      if (bit_cnt_en_i && bit_end_o)
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign idx_o     = idx_q;
  assign idx_nxt_o = idx_d;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_STOP2_EN for two stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      Tx_CLK,
  input  logic                      Tx_RST,
  input  logic [PRESCALE_WIDTH-1:0] Tx_prescale,
  input  logic                      Tx_par_en,
  input  logic                      Tx_par_typ,
  input  logic                      Tx_data_valid,
  input  logic [DATA_WIDTH-1:0]     Tx_p_data,
  output logic                      Tx_ready,
  output logic                      Tx_busy,
  output logic                      Tx_out
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);
`ifdef UART_TX_STOP2_EN
  localparam tx_state_t LAST_STOP = STOP2;
`else
  localparam tx_state_t LAST_STOP = STOP;
`endif

  tx_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]     data_q;
  logic [PRESCALE_WIDTH-1:0] pre_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic                      busy_q;
  logic                      out_q, out_d;

  logic [PRESCALE_WIDTH-1:0] cnt;
  logic [IW-1:0]             idx, idx_nxt;
  logic                      bit_end;
  logic                      accept;
  logic                      par_bit;

  tx_baud_bit_counter #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH)
  ) u_cnt (
    .clk_i        (Tx_CLK),
    .rst_ni       (Tx_RST),
    .en_i         (state_q != IDLE),
    .prescale_i   (pre_q),
    .bit_cnt_en_i (state_q == DATA),
    .cnt_o        (cnt),
    .idx_o        (idx),
    .idx_nxt_o    (idx_nxt),
    .bit_end_o    (bit_end)
  );

  assign Tx_ready = (state_q == IDLE) |
                    ((state_q == LAST_STOP) & bit_end);
  assign accept   = Tx_data_valid & Tx_ready;
  assign par_bit  = (^data_q) ^ (par_typ_q == PAR_ODD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (accept) state_d = START;
      START:
        if (bit_end) state_d = DATA;
      DATA:
        if (bit_end && idx == IDX_LAST)
          state_d = par_en_q ? PARITY : STOP;
      PARITY:
        if (bit_end) state_d = STOP;
`ifdef UART_TX_STOP2_EN
      STOP:
        if (bit_end) state_d = STOP2;
      STOP2:
        if (bit_end) state_d = accept ? START : IDLE;
`else
      STOP:
        if (bit_end) state_d = accept ? START : IDLE;
`endif
      default:
        state_d = IDLE;
    endcase
  end

  // Line level is registered from the next state so it moves with it.
  always_comb begin
    out_d = UART_IDLE_LVL;
    case (state_d)
      START:   out_d = UART_START_LVL;
      DATA:    out_d = data_q[idx_nxt];
      PARITY:  out_d = par_bit;
      default: out_d = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge Tx_CLK or negedge Tx_RST) begin
    if (!Tx_RST) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      out_q   <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      out_q   <= out_d;
    end
  end

  always_ff @(posedge Tx_CLK or negedge Tx_RST) begin
    if (!Tx_RST) begin
      data_q    <= '0;
      pre_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else if (accept) begin
      data_q    <= Tx_p_data;
      pre_q     <= Tx_prescale;
      par_en_q  <= Tx_par_en;
      par_typ_q <= Tx_par_typ;
    end
  end

  assign Tx_busy = busy_q;
  assign Tx_out  = out_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame; samples on the falling edge.
// Build with UART_TX_STOP2_EN to exercise the two-stop-bit variant.
module tb_uart_tx_frame;

`ifdef UART_TX_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Tx_prescale;
  logic       Tx_par_en;
  logic       Tx_par_typ;
  logic       Tx_data_valid;
  logic [7:0] Tx_p_data;
  logic       Tx_ready;
  logic       Tx_busy;
  logic       Tx_out;

  int errs   = 0;
  int checks = 0;

  uart_tx_frame dut (
    .Tx_CLK        (clk),
    .Tx_RST        (rst_n),
    .Tx_prescale   (Tx_prescale),
    .Tx_par_en     (Tx_par_en),
    .Tx_par_typ    (Tx_par_typ),
    .Tx_data_valid (Tx_data_valid),
    .Tx_p_data     (Tx_p_data),
    .Tx_ready      (Tx_ready),
    .Tx_busy       (Tx_busy),
    .Tx_out        (Tx_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic offer(input logic [7:0] d, input int pre,
                       input logic pe, input logic pt, input bit hold);
    int n;
    @(negedge clk);
    Tx_p_data     = d;
    Tx_prescale   = 5'(pre);
    Tx_par_en     = pe;
    Tx_par_typ    = pt;
    Tx_data_valid = 1'b1;
    n = 0;
    while (!Tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("offer_timeout", 32'(Tx_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) Tx_data_valid = 1'b0;
  endtask

  // Walks one frame clock by clock; pbit is the hand-computed parity bit.
  task automatic expect_frame(input string tag, input logic [7:0] d,
                              input logic pe, input logic pbit,
                              input int pre, input bit toggle);
    logic [15:0] f;
    int nbits;
    bit last;
    f      = 16'hFFFF;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (pe) f[9] = pbit;
    nbits = 9 + int'(pe) + NSTOP;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c <= pre; c++) begin
        @(negedge clk);
        last = (b == nbits - 1) && (c == pre);
        chk({tag, "_out"},   32'(Tx_out),   32'(f[b]));
        chk({tag, "_busy"},  32'(Tx_busy),  32'd1);
        chk({tag, "_ready"}, 32'(Tx_ready), 32'(last));
        if (toggle) begin
          Tx_data_valid = last ? 1'b0 : 1'($urandom_range(0, 1));
          Tx_p_data     = 8'($urandom);
          Tx_prescale   = 5'($urandom);
          Tx_par_en     = 1'($urandom_range(0, 1));
          Tx_par_typ    = 1'($urandom_range(0, 1));
        end
      end
    end
  endtask

  task automatic idle_chk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_out"},   32'(Tx_out),   32'd1);
      chk({tag, "_busy"},  32'(Tx_busy),  32'd0);
      chk({tag, "_ready"}, 32'(Tx_ready), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Tx_prescale   = 5'($urandom);
      Tx_par_en     = 1'($urandom_range(0, 1));
      Tx_par_typ    = 1'($urandom_range(0, 1));
      Tx_data_valid = 1'($urandom_range(0, 1));
      Tx_p_data     = 8'($urandom);
      @(negedge clk);
      chk("rst_out",   32'(Tx_out),   32'd1);
      chk("rst_busy",  32'(Tx_busy),  32'd0);
      chk("rst_ready", 32'(Tx_ready), 32'd1);
    end
    Tx_data_valid = 1'b0;
    rst_n = 1'b1;
    idle_chk("post_rst", 4);

    offer(8'hA5, 7, 1'b0, 1'b0, 1'b0);
    expect_frame("a5_p7", 8'hA5, 1'b0, 1'b0, 7, 1'b0);
    idle_chk("a5_idle", 2);

    // 8'h07 has three ones: even parity 1, odd parity 0
    offer(8'h07, 3, 1'b1, 1'b0, 1'b0);
    expect_frame("07_even", 8'h07, 1'b1, 1'b1, 3, 1'b0);
    idle_chk("07e_idle", 1);
    offer(8'h07, 3, 1'b1, 1'b1, 1'b0);
    expect_frame("07_odd", 8'h07, 1'b1, 1'b0, 3, 1'b0);
    idle_chk("07o_idle", 1);

    offer(8'h55, 0, 1'b0, 1'b0, 1'b1);
    Tx_p_data = 8'hAA;
    expect_frame("b2b_55", 8'h55, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #1;
    Tx_data_valid = 1'b0;
    expect_frame("b2b_aa", 8'hAA, 1'b0, 1'b0, 0, 1'b0);
    idle_chk("b2b_idle", 2);

    offer(8'h00, 3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("mid_data_out", 32'(Tx_out), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out",   32'(Tx_out),   32'd1);
    chk("abort_busy",  32'(Tx_busy),  32'd0);
    chk("abort_ready", 32'(Tx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_chk("abort_idle", 3);
    // 8'h3C has four ones: odd parity 1
    offer(8'h3C, 2, 1'b1, 1'b1, 1'b0);
    expect_frame("3c_odd", 8'h3C, 1'b1, 1'b1, 2, 1'b0);
    idle_chk("3c_idle", 1);

    offer(8'hC3, 1, 1'b0, 1'b0, 1'b0);
    expect_frame("c3_tog", 8'hC3, 1'b0, 1'b0, 1, 1'b1);
    Tx_data_valid = 1'b0;
    idle_chk("tog_idle", 8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
